// File: rtl/fip_seq_div_sqrt_pkg.sv
// Shared types and limit helper for the fixed-point divide / square-root unit.
package fip_pkg;

  typedef enum logic {
    FIP_DIV  = 1'b0,
    FIP_SQRT = 1'b1
  } fip_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } fip_state_e;

  // Raw bit pattern of the largest (neg=0) or smallest (neg=1) w-bit signed value;
  // the neg=1 pattern also reads as the unsigned magnitude 2^(w-1).
  function automatic logic [63:0] fip_limit(input int w, input logic neg);
    logic [63:0] msb;
    msb = 64'd1 << (w - 1);
    return neg ? msb : msb - 64'd1;
  endfunction

endpackage

// File: rtl/fip_seq_div_sqrt_if.sv
// Request/result handshake bundle of the divide / square-root unit.
interface fip_seq_div_sqrt_if #(
  parameter int W = 32
);
  logic         i_valid;
  logic         o_ready;
  logic         i_mode;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_result;
  logic         o_overflow;
  logic         o_invalid;

  modport master (
    output i_valid, i_mode, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_result, o_overflow, o_invalid
  );

  modport slave (
    input  i_valid, i_mode, i_a, i_b, i_ready,
    output o_ready, o_valid, o_result, o_overflow, o_invalid
  );
endinterface

// File: rtl/fip_seq_div_sqrt_sign_sat.sv
// Applies the result sign to an unsigned magnitude and flags divide overflow.
// Clamps overflowing quotients to max/min when FIP_SATURATE_EN is defined.
module fip_sign_sat
  import fip_pkg::*;
#(
  parameter int W     = 32,
  parameter int MAG_W = 48
) (
  input  logic [MAG_W-1:0] mag,
  input  logic             neg,
  input  fip_mode_e        mode,
  output logic [W-1:0]     result,
  output logic             overflow
);
  localparam logic [MAG_W-1:0] POS_LIM = MAG_W'(fip_limit(W, 1'b0));
  localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(fip_limit(W, 1'b1));

  logic         neg_eff;
  logic [W-1:0] raw;

  // A zero quotient stays positive even when the operand signs differ.
  assign neg_eff  = neg & (|mag);
  assign overflow = (mode == FIP_DIV) & (neg_eff ? (mag > NEG_LIM) : (mag > POS_LIM));
  assign raw      = neg_eff ? -mag[W-1:0] : mag[W-1:0];

`ifdef FIP_SATURATE_EN
  assign result = overflow ? (neg_eff ? NEG_LIM[W-1:0] : POS_LIM[W-1:0]) : raw;
`else
  assign result = raw;
`endif

endmodule

// File: rtl/fip_seq_div_sqrt.sv
// Iterative signed Q(INT_BITS).(FRAC_BITS) divider / square root, one result bit per cycle.
// Optional build macro FIP_SATURATE_EN: saturate overflow and divide-by-zero results.
//
// state | meaning
// IDLE  | waiting for a request, o_ready high
// CALC  | restoring divide / root iterations running
// DONE  | result held on o_valid until i_ready
module fip_seq_div_sqrt
  import fip_pkg::*;
#(
  parameter int INT_BITS  = 16,
  parameter int FRAC_BITS = 16
) (
  input logic               i_clk,
  input logic               i_rst,
  fip_seq_div_sqrt_if.slave bus
);
  localparam int W          = INT_BITS + FRAC_BITS;
  localparam int DIV_ITERS  = W + FRAC_BITS;
  localparam int SQRT_ITERS = (W + FRAC_BITS) / 2;
  localparam int MAG_W      = W + FRAC_BITS;
  localparam int REM_W      = W + 2;
  localparam int CNT_W      = $clog2(DIV_ITERS + 1);
`ifdef FIP_SATURATE_EN
  localparam logic [W-1:0] SAT_MAX = W'(fip_limit(W, 1'b0));
  localparam logic [W-1:0] SAT_MIN = W'(fip_limit(W, 1'b1));
`endif

  fip_state_e       state, state_nxt;
  fip_mode_e        mode_q, req_mode;
  logic             neg_q;
  logic [REM_W-1:0] rem_q, rem_nxt;
  logic [MAG_W-1:0] work_q, work_nxt;
  logic [MAG_W-1:0] quo_q, quo_nxt;
  logic [W:0]       den_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     result_q, ss_result, dz_result;
  logic             ovf_q, inv_q, ss_ovf;
  logic             accept, special, last_iter, ready_int, valid_int;
  logic [W:0]       a_ext, b_ext, a_mag, b_mag;
  logic [REM_W-1:0] div_sh, div_den, sq_sh, sq_trial;
  logic             div_ge, sq_ge;
  logic             unused_bits;

  assign req_mode  = fip_mode_e'(bus.i_mode);
  assign accept    = bus.i_valid & ~i_rst & (state == IDLE);
  assign special   = (req_mode == FIP_DIV) ? (bus.i_b == '0) : bus.i_a[W-1];
  assign last_iter = (cnt_q == CNT_W'(1));

  // W+1-bit magnitudes keep |MIN| exact.
  assign a_ext = {bus.i_a[W-1], bus.i_a};
  assign b_ext = {bus.i_b[W-1], bus.i_b};
  assign a_mag = bus.i_a[W-1] ? -a_ext : a_ext;
  assign b_mag = bus.i_b[W-1] ? -b_ext : b_ext;

`ifdef FIP_SATURATE_EN
  assign dz_result = bus.i_a[W-1] ? SAT_MIN : SAT_MAX;
`else
  assign dz_result = '0;
`endif

  assign div_sh   = {rem_q[REM_W-2:0], work_q[MAG_W-1]};
  assign div_den  = {1'b0, den_q};
  assign div_ge   = div_sh >= div_den;
  assign sq_sh    = {rem_q[REM_W-3:0], work_q[MAG_W-1 -: 2]};
  assign sq_trial = {quo_q[REM_W-3:0], 2'b01};
  assign sq_ge    = sq_sh >= sq_trial;

  always_comb begin
    rem_nxt  = rem_q;
    work_nxt = work_q;
    quo_nxt  = quo_q;
    if (mode_q == FIP_DIV) begin
      rem_nxt  = div_ge ? (div_sh - div_den) : div_sh;
      work_nxt = {work_q[MAG_W-2:0], 1'b0};
      quo_nxt  = {quo_q[MAG_W-2:0], div_ge};
    end else begin
      rem_nxt  = sq_ge ? (sq_sh - sq_trial) : sq_sh;
      work_nxt = {work_q[MAG_W-3:0], 2'b00};
      quo_nxt  = {quo_q[MAG_W-2:0], sq_ge};
    end
  end

  // Fed with the next quotient so sign and overflow land on the CALC->DONE edge.
  fip_sign_sat #(
    .W     (W),
    .MAG_W (MAG_W)
  ) u_sign_sat (
    .mag      (quo_nxt),
    .neg      (neg_q),
    .mode     (mode_q),
    .result   (ss_result),
    .overflow (ss_ovf)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_int = 1'b0;
    valid_int = 1'b0;
    case (state)
      IDLE: begin
        ready_int = ~i_rst;
        if (accept) state_nxt = special ? DONE : CALC;
      end
      CALC: if (last_iter) state_nxt = DONE;
      DONE: begin
        valid_int = 1'b1;
        if (bus.i_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_q   <= FIP_DIV;
      neg_q    <= 1'b0;
      rem_q    <= '0;
      work_q   <= '0;
      quo_q    <= '0;
      den_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          mode_q <= req_mode;
          rem_q  <= '0;
          quo_q  <= '0;
          den_q  <= b_mag;
          if (req_mode == FIP_DIV) begin
            neg_q  <= bus.i_a[W-1] ^ bus.i_b[W-1];
            work_q <= {a_mag[W-1:0], {FRAC_BITS{1'b0}}};
            cnt_q  <= CNT_W'(DIV_ITERS);
          end else begin
            neg_q  <= 1'b0;
            work_q <= {bus.i_a, {FRAC_BITS{1'b0}}};
            cnt_q  <= CNT_W'(SQRT_ITERS);
          end
          if (special) begin
            result_q <= (req_mode == FIP_DIV) ? dz_result : '0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b1;
          end
        end
        CALC: begin
          rem_q  <= rem_nxt;
          work_q <= work_nxt;
          quo_q  <= quo_nxt;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (last_iter) begin
            result_q <= ss_result;
            ovf_q    <= ss_ovf;
            inv_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign unused_bits = ^{rem_q[REM_W-1], quo_q[MAG_W-1], a_mag[W]};

  assign bus.o_ready    = ready_int;
  assign bus.o_valid    = valid_int;
  assign bus.o_result   = result_q;
  assign bus.o_overflow = ovf_q;
  assign bus.o_invalid  = inv_q;

endmodule

// File: tb/tb_fip_seq_div_sqrt.sv
// Directed-vector bench for fip_seq_div_sqrt in the default Q16.16 format.
module tb_fip_seq_div_sqrt;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fip_seq_div_sqrt_if #(.W(32)) bus ();

  fip_seq_div_sqrt #(
    .INT_BITS  (16),
    .FRAC_BITS (16)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

`ifdef FIP_SATURATE_EN
  localparam logic [31:0] EXP_OVF_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] EXP_OVF_MIN = 32'h7FFF_FFFF;
  localparam logic [31:0] EXP_DZ      = 32'h8000_0000;
`else
  localparam logic [31:0] EXP_OVF_POS = 32'hFFFF_FFFE;
  localparam logic [31:0] EXP_OVF_MIN = 32'h8000_0000;
  localparam logic [31:0] EXP_DZ      = 32'h0000_0000;
`endif

  typedef struct {
    logic        mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        inv;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic send(input logic mode, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    @(negedge clk);
    while (!bus.o_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("send_timeout", 32'(guard), 32'd0);
    bus.i_valid = 1'b1;
    bus.i_mode  = mode;
    bus.i_a     = a;
    bus.i_b     = b;
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
  endtask

  // Called at #1 after the accept edge; returns the edge count until o_valid.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!bus.o_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic retire(input string tag);
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1 bus.i_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(bus.o_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(bus.o_ready), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    string tag;

    vecs.push_back('{1'b0, 32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 1'b0, 1'b0, 49});
    vecs.push_back('{1'b0, 32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 1'b0, 1'b0, 49});
    vecs.push_back('{1'b0, 32'h7FFF_FFFF, 32'h0000_8000, EXP_OVF_POS,  1'b1, 1'b0, 49});
    vecs.push_back('{1'b0, 32'h8000_0000, 32'hFFFF_0000, EXP_OVF_MIN,  1'b1, 1'b0, 49});
    vecs.push_back('{1'b0, 32'hFFFE_0000, 32'h0000_0000, EXP_DZ,       1'b0, 1'b1, 1});
    vecs.push_back('{1'b1, 32'h0002_0000, 32'h0000_0000, 32'h0001_6A09, 1'b0, 1'b0, 25});
    vecs.push_back('{1'b1, 32'hFFFF_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 25});
    vecs.push_back('{1'b1, 32'h0001_0000, 32'h0000_0000, 32'h0001_0000, 1'b0, 1'b0, 25});
    vecs.push_back('{1'b1, 32'h0000_0001, 32'h0000_0000, 32'h0000_0100, 1'b0, 1'b0, 25});
    vecs.push_back('{1'b1, 32'h7FFF_FFFF, 32'h0000_0000, 32'h00B5_04F3, 1'b0, 1'b0, 25});
    vecs.push_back('{1'b0, 32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0, 49});
    vecs.push_back('{1'b0, 32'h7FFF_FFFF, 32'h0001_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 49});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'hFFFB_0000, 32'h0000_0000, 1'b0, 1'b0, 49});
    vecs.push_back('{1'b0, 32'hFFFA_0000, 32'h0002_0000, 32'hFFFD_0000, 1'b0, 1'b0, 49});
    vecs.push_back('{1'b0, 32'h0001_0000, 32'hFFFF_8000, 32'hFFFE_0000, 1'b0, 1'b0, 49});

    bus.i_valid = 1'b0;
    bus.i_mode  = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_ready = 1'b0;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready",    32'(bus.o_ready),    32'd0);
    check("rst_valid",    32'(bus.o_valid),    32'd0);
    check("rst_result",   bus.o_result,        32'd0);
    check("rst_overflow", 32'(bus.o_overflow), 32'd0);
    check("rst_invalid",  32'(bus.o_invalid),  32'd0);
    rst = 1'b0;
    #1 check("ready_after_rst", 32'(bus.o_ready), 32'd1);

    foreach (vecs[i]) begin
      tag = $sformatf("v%0d", i);
      send(vecs[i].mode, vecs[i].a, vecs[i].b);
      wait_result(lat);
      check({tag, "_latency"},  32'(lat),            32'(vecs[i].lat));
      check({tag, "_result"},   bus.o_result,        vecs[i].res);
      check({tag, "_overflow"}, 32'(bus.o_overflow), 32'(vecs[i].ovf));
      check({tag, "_invalid"},  32'(bus.o_invalid),  32'(vecs[i].inv));
      retire(tag);
    end

    // Backpressure: result held, and a competing request stays unaccepted.
    send(1'b0, 32'h0006_0000, 32'h0002_0000);
    wait_result(lat);
    check("bp_latency", 32'(lat), 32'd49);
    bus.i_valid = 1'b1;
    bus.i_mode  = 1'b1;
    bus.i_a     = 32'h0009_0000;
    repeat (10) begin
      @(posedge clk);
      #1;
      check("bp_valid",  32'(bus.o_valid), 32'd1);
      check("bp_result", bus.o_result,     32'h0003_0000);
      check("bp_ready",  32'(bus.o_ready), 32'd0);
    end
    bus.i_valid = 1'b0;
    retire("bp");

    // Reset in the middle of CALC aborts the divide.
    send(1'b0, 32'h0006_0000, 32'h0002_0000);
    repeat (9) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1 check("abort_ready_in_rst", 32'(bus.o_ready), 32'd0);
    @(negedge clk) rst = 1'b0;
    #1;
    check("abort_valid", 32'(bus.o_valid), 32'd0);
    check("abort_ready", 32'(bus.o_ready), 32'd1);
    repeat (60) @(posedge clk);
    #1 check("abort_no_result", 32'(bus.o_valid), 32'd0);
    send(1'b1, 32'h0002_0000, 32'h0000_0000);
    wait_result(lat);
    check("post_abort_latency", 32'(lat),     32'd25);
    check("post_abort_result",  bus.o_result, 32'h0001_6A09);
    retire("post_abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
